fft_frame_sched: RTL and testbench
==================================

FFT_FRAME_SCHED -- requirements
Module: fft_frame_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the sample real/imag bit width.
REQ-002 SHALL have parameter LOG_N, default 6, meaning log2 of the FFT frame length N (N=64).
REQ-003 SHALL have parameter TAG_DEPTH, default 4, meaning the number of frames tracked in flight.
REQ-004 clock  in  1  master clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 s0_valid/s1_valid  in  1  requester k has a sample available.
REQ-007 s0_ready/s1_ready  out  1  requester k sample accepted this cycle.
REQ-008 s0_re/s0_im/s1_re/s1_im  in  WIDTH  requester sample data.
REQ-009 fft_di_en  out  1  FFT pipeline input enable.
REQ-010 fft_di_re/fft_di_im  out  WIDTH  FFT pipeline input data.
REQ-011 fft_do_en  in  1  FFT pipeline output enable.
REQ-012 fft_do_re/fft_do_im  in  WIDTH  FFT pipeline output data.
REQ-013 m_valid  out  1  result sample valid; no backpressure.
REQ-014 m_re/m_im  out  WIDTH  result data.
REQ-015 m_index  out  LOG_N  bin index of the result sample.
REQ-016 m_last  out  1  final sample of a result frame.
REQ-017 m_src  out  1  requester that owns the current result frame.
REQ-018 underrun/orphan  out  1  sticky error flags.
REQ-019 err_clr  in  1  synchronous clear of the sticky flags.

Function
REQ-020 States: IDLE and RUN; grant register g (0/1); input counter in_cnt (LOG_N bits).
REQ-021 sk_ready SHALL be 1 only when state==RUN and g==k; it is combinational from registered state.
REQ-022 Arbitration (IDLE, or RUN with in_cnt==N-1): candidates are sk_valid=1; both pending -> pick !last_src; one pending -> pick it; tag FIFO full -> no grant.
REQ-023 A grant SHALL move to RUN (or stay in RUN) next cycle with g=winner, in_cnt=0, last_src=winner, and the winner pushed into the tag FIFO; no grant -> IDLE.
REQ-024 Each RUN cycle: fft_di_en<=1, fft_di_re/im<=granted sample if valid, else 0 and underrun<=1 (zero-fill); in_cnt increments.
REQ-025 Input latency: a sample accepted at cycle t SHALL appear on fft_di_* at t+1; back-to-back frames SHALL give contiguous fft_di_en with no bubble.
REQ-026 In IDLE, fft_di_en<=0 and fft_di_re/im hold.
REQ-027 Output stage registers one cycle: m_valid<=fft_do_en, m_re/im<=fft_do_re/im; out_cnt increments per fft_do_en and wraps N-1->0.
REQ-028 m_last SHALL be 1 when out_cnt==N-1; m_src = tag FIFO head; pop occurs on the m_last cycle.
REQ-029 fft_do_en with empty tag FIFO SHALL set orphan; m_src=0 then and no pop.
REQ-030 Push and pop in the same cycle SHALL keep occupancy unchanged; full is checked before the pop.
REQ-031 err_clr SHALL clear flags unless a set event occurs the same cycle (set wins).

Reset
REQ-032 Reset SHALL force: state IDLE, g=0, last_src=1, in_cnt=0, out_cnt=0, tag FIFO empty, fft_di_en=0, m_valid=0, m_last=0, underrun=0, orphan=0, fft_di_re/im=0, m_re/im=0, m_index=0, m_src=0.
REQ-033 Reset mid-frame SHALL abandon the partial frame; no frame is resumed after release.

Configuration
REQ-034 Macro FFT_SCHED_BITREV_IDX_EN defined: m_index = bit-reversed out_cnt (natural-order bin for R2^2 SDF output); undefined: m_index = out_cnt.

Verification
REQ-035 s0 valid continuously for 64 cycles from reset -> s0_ready for 64 cycles, fft_di_en 64 contiguous cycles one cycle later, underrun=0.
REQ-036 s0 and s1 both valid continuously -> frames alternate s0,s1,s0 with no fft_di_en gap; m_src sequence 0,1,0.
REQ-037 s1 valid drops at in_cnt=10 for 3 cycles -> fft_di_re/im=0 for those 3 samples, frame still 64 long, underrun=1 until err_clr.
REQ-038 Hold fft_do_en low with both requesters valid -> 4 frames granted, then no grant (ready=0) until one m_last pops the FIFO.
REQ-039 fft_do_en pulse with no frame issued -> orphan=1, m_valid=1, m_src=0.
REQ-040 Macro defined, out_cnt=1 -> m_index=32; macro undefined -> m_index=1.

Source files
------------

// File: rtl/fft_frame_sched_if.sv
// Signal bundle between the frame scheduler, its two sample requesters,
// the streaming FFT core and the result sink.
interface fft_frame_sched_if #(
    parameter int WIDTH = 16,
    parameter int LOG_N = 6
);
    logic             s0_valid;
    logic             s1_valid;
    logic             s0_ready;
    logic             s1_ready;
    logic [WIDTH-1:0] s0_re;
    logic [WIDTH-1:0] s0_im;
    logic [WIDTH-1:0] s1_re;
    logic [WIDTH-1:0] s1_im;

    logic             fft_di_en;
    logic [WIDTH-1:0] fft_di_re;
    logic [WIDTH-1:0] fft_di_im;
    logic             fft_do_en;
    logic [WIDTH-1:0] fft_do_re;
    logic [WIDTH-1:0] fft_do_im;

    logic             m_valid;
    logic [WIDTH-1:0] m_re;
    logic [WIDTH-1:0] m_im;
    logic [LOG_N-1:0] m_index;
    logic             m_last;
    logic             m_src;

    logic             underrun;
    logic             orphan;
    logic             err_clr;

    // Environment side: requesters, FFT core output and error-clear source.
    modport master (
        output s0_valid, s1_valid, s0_re, s0_im, s1_re, s1_im,
        output fft_do_en, fft_do_re, fft_do_im, err_clr,
        input  s0_ready, s1_ready, fft_di_en, fft_di_re, fft_di_im,
        input  m_valid, m_re, m_im, m_index, m_last, m_src, underrun, orphan
    );

    // Scheduler side.
    modport slave (
        input  s0_valid, s1_valid, s0_re, s0_im, s1_re, s1_im,
        input  fft_do_en, fft_do_re, fft_do_im, err_clr,
        output s0_ready, s1_ready, fft_di_en, fft_di_re, fft_di_im,
        output m_valid, m_re, m_im, m_index, m_last, m_src, underrun, orphan
    );
endinterface

// File: rtl/fft_frame_sched.sv
// Two-requester frame scheduler for a streaming FFT: grants whole N-sample frames, tags each
// frame with its owner and labels the returning results. FFT_SCHED_BITREV_IDX_EN: bit-reversed m_index.
module fft_frame_sched #(
    parameter int WIDTH     = 16,
    parameter int LOG_N     = 6,
    parameter int TAG_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    fft_frame_sched_if.slave bus
);
    localparam int N     = 1 << LOG_N;
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);
    localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             g_q, g_d;
    logic             last_src_q, last_src_d;
    logic [LOG_N-1:0] in_cnt_q, in_cnt_d;
    logic [LOG_N-1:0] out_cnt_q, out_cnt_d;

    logic             tag_mem_q [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] tag_cnt_q, tag_cnt_d;

    logic             di_en_q, di_en_d;
    logic [WIDTH-1:0] di_re_q, di_re_d;
    logic [WIDTH-1:0] di_im_q, di_im_d;

    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_re_q, m_re_d;
    logic [WIDTH-1:0] m_im_q, m_im_d;
    logic [LOG_N-1:0] m_index_q, m_index_d;
    logic             m_last_q, m_last_d;
    logic             m_src_q, m_src_d;
    logic             underrun_q, underrun_d;
    logic             orphan_q, orphan_d;

    logic             arb_en, tag_full, tag_empty, any_req, winner, grant;
    logic             push, pop, sel_valid, out_last, underrun_set, orphan_set;
    logic [LOG_N-1:0] idx_w;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(TAG_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Arbitration window: idle, or the cycle carrying the final sample of the current frame.
    assign arb_en    = (state_q == ST_IDLE) || (in_cnt_q == LAST_IDX);
    assign tag_full  = (tag_cnt_q == CNT_W'(TAG_DEPTH));
    assign tag_empty = (tag_cnt_q == '0);
    assign any_req   = bus.s0_valid | bus.s1_valid;
    assign winner    = (bus.s0_valid && bus.s1_valid) ? ~last_src_q : bus.s1_valid;
    assign grant     = arb_en && any_req && !tag_full;
    assign push      = grant;
    assign sel_valid = g_q ? bus.s1_valid : bus.s0_valid;
    assign out_last  = (out_cnt_q == LAST_IDX);
    assign pop       = bus.fft_do_en && out_last && !tag_empty;

`ifdef FFT_SCHED_BITREV_IDX_EN
    genvar gi;
    generate
        for (gi = 0; gi < LOG_N; gi++) begin : g_bitrev
            assign idx_w[gi] = out_cnt_q[LOG_N-1-gi];
        end
    endgenerate
`else
    assign idx_w = out_cnt_q;
`endif

    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        last_src_d   = last_src_q;
        in_cnt_d     = in_cnt_q;
        di_en_d      = 1'b0;
        di_re_d      = di_re_q;
        di_im_d      = di_im_q;
        underrun_set = 1'b0;
        if (state_q == ST_RUN) begin
            di_en_d  = 1'b1;
            in_cnt_d = in_cnt_q + LOG_N'(1);
            if (sel_valid) begin
                di_re_d = g_q ? bus.s1_re : bus.s0_re;
                di_im_d = g_q ? bus.s1_im : bus.s0_im;
            end else begin
                di_re_d      = '0;
                di_im_d      = '0;
                underrun_set = 1'b1;
            end
        end
        if (arb_en) begin
            if (grant) begin
                state_d    = ST_RUN;
                g_d        = winner;
                in_cnt_d   = '0;
                last_src_d = winner;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        m_valid_d  = bus.fft_do_en;
        m_last_d   = bus.fft_do_en && out_last;
        m_re_d     = m_re_q;
        m_im_d     = m_im_q;
        m_index_d  = m_index_q;
        m_src_d    = m_src_q;
        out_cnt_d  = out_cnt_q;
        orphan_set = 1'b0;
        if (bus.fft_do_en) begin
            m_re_d     = bus.fft_do_re;
            m_im_d     = bus.fft_do_im;
            m_index_d  = idx_w;
            m_src_d    = tag_empty ? 1'b0 : tag_mem_q[rd_ptr_q];
            orphan_set = tag_empty;
            out_cnt_d  = out_cnt_q + LOG_N'(1);
        end
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        tag_cnt_d  = tag_cnt_q + CNT_W'(push) - CNT_W'(pop);
        // A set event in the same cycle as err_clr keeps the flag raised.
        underrun_d = underrun_set | (underrun_q & ~bus.err_clr);
        orphan_d   = orphan_set | (orphan_q & ~bus.err_clr);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            g_q        <= 1'b0;
            last_src_q <= 1'b1;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tag_cnt_q  <= '0;
            di_en_q    <= 1'b0;
            di_re_q    <= '0;
            di_im_q    <= '0;
            m_valid_q  <= 1'b0;
            m_re_q     <= '0;
            m_im_q     <= '0;
            m_index_q  <= '0;
            m_last_q   <= 1'b0;
            m_src_q    <= 1'b0;
            underrun_q <= 1'b0;
            orphan_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            last_src_q <= last_src_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tag_cnt_q  <= tag_cnt_d;
            di_en_q    <= di_en_d;
            di_re_q    <= di_re_d;
            di_im_q    <= di_im_d;
            m_valid_q  <= m_valid_d;
            m_re_q     <= m_re_d;
            m_im_q     <= m_im_d;
            m_index_q  <= m_index_d;
            m_last_q   <= m_last_d;
            m_src_q    <= m_src_d;
            underrun_q <= underrun_d;
            orphan_q   <= orphan_d;
        end
    end

    // Tag storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= winner;
        end
    end

    assign bus.s0_ready  = (state_q == ST_RUN) && !g_q;
    assign bus.s1_ready  = (state_q == ST_RUN) && g_q;
    assign bus.fft_di_en = di_en_q;
    assign bus.fft_di_re = di_re_q;
    assign bus.fft_di_im = di_im_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_re      = m_re_q;
    assign bus.m_im      = m_im_q;
    assign bus.m_index   = m_index_q;
    assign bus.m_last    = m_last_q;
    assign bus.m_src     = m_src_q;
    assign bus.underrun  = underrun_q;
    assign bus.orphan    = orphan_q;
endmodule

// File: tb/tb_fft_frame_sched.sv
// Bench for fft_frame_sched: frame-level reference model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_fft_frame_sched;
    localparam int WIDTH     = 16;
    localparam int LOG_N     = 6;
    localparam int N         = 64;
    localparam int TAG_DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    fft_frame_sched_if #(.WIDTH(WIDTH), .LOG_N(LOG_N)) bus ();

    fft_frame_sched #(.WIDTH(WIDTH), .LOG_N(LOG_N), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame view) ----------------
    bit               md_busy        = 1'b0;  // a frame is being streamed into the FFT
    bit               md_owner       = 1'b0;
    int               md_fed         = 0;     // samples of the current frame already streamed
    bit               md_prev_winner = 1'b1;
    bit               md_tags[$];             // owners of frames not yet returned
    int               md_out_pos     = 0;     // position inside the returning result frame
    bit               ex_di_en = 1'b0;
    logic [WIDTH-1:0] ex_di_re = '0, ex_di_im = '0;
    bit               ex_mv = 1'b0, ex_mlast = 1'b0, ex_msrc = 1'b0;
    logic [WIDTH-1:0] ex_mre = '0, ex_mim = '0;
    logic [LOG_N-1:0] ex_midx = '0;
    bit               ex_und = 1'b0, ex_orph = 1'b0;

    function automatic logic [LOG_N-1:0] exp_index(input int pos);
        int r;
        r = pos;
`ifdef FFT_SCHED_BITREV_IDX_EN
        r = 0;
        for (int b = 0; b < LOG_N; b++)
            if (((pos >> b) & 1) == 1) r = r + (1 << (LOG_N - 1 - b));
`endif
        return LOG_N'(r);
    endfunction

    always @(posedge clock or posedge reset) begin : model
        bit full_now, may_pick, src_ok, und_set, orph_set, do_push, pick;
        if (reset) begin
            md_busy = 0; md_owner = 0; md_fed = 0; md_prev_winner = 1;
            md_tags.delete(); md_out_pos = 0;
            ex_di_en = 0; ex_di_re = '0; ex_di_im = '0;
            ex_mv = 0; ex_mlast = 0; ex_msrc = 0; ex_mre = '0; ex_mim = '0; ex_midx = '0;
            ex_und = 0; ex_orph = 0;
        end else begin
            full_now = (md_tags.size() == TAG_DEPTH);
            may_pick = !md_busy || (md_fed == N - 1);
            und_set = 0; orph_set = 0; do_push = 0; pick = 0;
            if (md_busy) begin
                src_ok   = md_owner ? bus.s1_valid : bus.s0_valid;
                ex_di_en = 1;
                ex_di_re = src_ok ? (md_owner ? bus.s1_re : bus.s0_re) : '0;
                ex_di_im = src_ok ? (md_owner ? bus.s1_im : bus.s0_im) : '0;
                und_set  = !src_ok;
                md_fed++;
            end else begin
                ex_di_en = 0;
            end
            if (may_pick) begin
                if (full_now || !(bus.s0_valid || bus.s1_valid)) begin
                    md_busy = 0;
                end else begin
                    pick = (bus.s0_valid && bus.s1_valid) ? !md_prev_winner : bus.s1_valid;
                    md_busy = 1; md_owner = pick; md_fed = 0; md_prev_winner = pick;
                    do_push = 1;
                end
            end
            if (bus.fft_do_en) begin
                ex_mv    = 1;
                ex_mre   = bus.fft_do_re;
                ex_mim   = bus.fft_do_im;
                ex_midx  = exp_index(md_out_pos);
                ex_mlast = (md_out_pos == N - 1);
                if (md_tags.size() == 0) begin
                    ex_msrc  = 0;
                    orph_set = 1;
                end else begin
                    ex_msrc = md_tags[0];
                    if (ex_mlast) void'(md_tags.pop_front());
                end
                md_out_pos = (md_out_pos + 1) % N;
            end else begin
                ex_mv    = 0;
                ex_mlast = 0;
            end
            if (do_push) md_tags.push_back(pick);
            ex_und  = und_set || (ex_und && !bus.err_clr);
            ex_orph = orph_set || (ex_orph && !bus.err_clr);
        end
    end

    always @(negedge clock) begin
        if (cmp_on) begin
            chk("s0_ready", bus.s0_ready, md_busy && !md_owner);
            chk("s1_ready", bus.s1_ready, md_busy && md_owner);
            chk("fft_di_en", bus.fft_di_en, ex_di_en);
            chk("fft_di_re", bus.fft_di_re, ex_di_re);
            chk("fft_di_im", bus.fft_di_im, ex_di_im);
            chk("m_valid", bus.m_valid, ex_mv);
            chk("m_last", bus.m_last, ex_mlast);
            chk("m_src", bus.m_src, ex_msrc);
            chk("m_re", bus.m_re, ex_mre);
            chk("m_im", bus.m_im, ex_mim);
            chk("m_index", bus.m_index, ex_midx);
            chk("underrun", bus.underrun, ex_und);
            chk("orphan", bus.orphan, ex_orph);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        bus.s0_valid = 0; bus.s1_valid = 0;
        bus.s0_re = '0; bus.s0_im = '0; bus.s1_re = '0; bus.s1_im = '0;
        bus.fft_do_en = 0; bus.fft_do_re = '0; bus.fft_do_im = '0;
        bus.err_clr = 0;
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clock);
        #2;
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time budget");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int               rdy_cnt, en_cnt, found;
        logic [WIDTH-1:0] samp [N];
        bit               src_seq[$];
        logic [LOG_N-1:0] idx_one;

        idle_inputs();
        @(posedge clock);
        cmp_on = 1'b1;
        step();
        chk("reset fft_di_en", bus.fft_di_en, 0);
        chk("reset m_valid", bus.m_valid, 0);
        chk("reset s0_ready", bus.s0_ready, 0);
        chk("reset underrun", bus.underrun, 0);
        chk("reset orphan", bus.orphan, 0);
        repeat (2) @(negedge clock);
        #2;
        reset = 1'b0;

        // A: single requester streams one full frame, then a mid-frame reset
        step();
        bus.s0_valid = 1; bus.s0_re = 16'h1234; bus.s0_im = 16'h5678;
        rdy_cnt = 0; en_cnt = 0;
        for (int i = 1; i <= 66; i++) begin
            step();
            if (i <= 64) rdy_cnt += int'(bus.s0_ready);
            if (i == 1) chk("A di_en before first sample", bus.fft_di_en, 0);
            if (i >= 2 && i <= 65) en_cnt += int'(bus.fft_di_en);
            if (i == 2) chk("A first sample re", bus.fft_di_re, 16'h1234);
            if (i == 65) chk("A underrun after frame", bus.underrun, 0);
            if (i == 66) chk("A next frame contiguous", bus.fft_di_en, 1);
        end
        chk("A s0_ready cycles", rdy_cnt, 64);
        chk("A di_en cycles", en_cnt, 64);
        apply_reset();
        repeat (3) step();
        chk("A no resume di_en", bus.fft_di_en, 0);
        chk("A no resume ready", bus.s0_ready, 0);

        // B: both requesters, FFT modelled as a one-cycle loopback
        apply_reset();
        step();
        bus.s0_valid = 1; bus.s1_valid = 1;
        en_cnt = 0;
        src_seq.delete();
        for (int i = 1; i <= 215; i++) begin
            step();
            if (bus.m_valid && bus.m_last) src_seq.push_back(bus.m_src);
            if (i >= 2 && i <= 193) en_cnt += int'(bus.fft_di_en);
            bus.fft_do_en = bus.fft_di_en;
            bus.fft_do_re = ~bus.fft_di_re;
            bus.fft_do_im = bus.fft_di_im ^ 16'h00FF;
            bus.s0_re = 16'h1000 + 16'(i); bus.s0_im = 16'h1800 + 16'(i);
            bus.s1_re = 16'h2000 + 16'(i); bus.s1_im = 16'h2800 + 16'(i);
        end
        chk("B di_en gapless over 3 frames", en_cnt, 192);
        chk("B m_src frame0", (src_seq.size() > 0) ? 32'(src_seq[0]) : 32'd2, 0);
        chk("B m_src frame1", (src_seq.size() > 1) ? 32'(src_seq[1]) : 32'd2, 1);
        chk("B m_src frame2", (src_seq.size() > 2) ? 32'(src_seq[2]) : 32'd2, 0);

        // C: s1 drops valid for samples 10..12, then err_clr behaviour
        apply_reset();
        step();
        bus.s1_valid = 1; bus.s1_re = 16'h0A00; bus.s1_im = 16'h0B00;
        en_cnt = 0;
        for (int n = 0; n <= 64; n++) begin
            step();
            if (n >= 1) begin
                samp[n-1] = bus.fft_di_re;
                en_cnt += int'(bus.fft_di_en);
            end
            if (n == 10) chk("C underrun before gap", bus.underrun, 0);
            if (n == 11) chk("C underrun at gap", bus.underrun, 1);
            if (n <= 63) begin
                bus.s1_valid = !(n >= 10 && n <= 12);
                bus.s1_re = 16'h0A00 + 16'(n);
                bus.s1_im = 16'h0B00 + 16'(n);
            end else begin
                bus.s1_valid = 0;
            end
        end
        chk("C sample 9", samp[9], 16'h0A09);
        chk("C sample 10 zero-fill", samp[10], 16'h0000);
        chk("C sample 11 zero-fill", samp[11], 16'h0000);
        chk("C sample 12 zero-fill", samp[12], 16'h0000);
        chk("C sample 13", samp[13], 16'h0A0D);
        chk("C sample 63", samp[63], 16'h0A3F);
        chk("C frame length", en_cnt, 64);
        step();
        bus.err_clr = 1;
        step();
        bus.err_clr = 0;
        chk("C set wins over err_clr", bus.underrun, 1);
        repeat (70) step();
        chk("C idle after frames", bus.fft_di_en, 0);
        bus.err_clr = 1;
        step();
        bus.err_clr = 0;
        chk("C underrun cleared", bus.underrun, 0);

        // D: no FFT output -> tag FIFO fills after four frames
        apply_reset();
        step();
        bus.s0_valid = 1; bus.s1_valid = 1;
        bus.s0_re = 16'h0D00; bus.s1_re = 16'h0E00;
        rdy_cnt = 0;
        for (int i = 1; i <= 280; i++) begin
            step();
            rdy_cnt += int'(bus.s0_ready | bus.s1_ready);
        end
        chk("D granted sample cycles", rdy_cnt, 256);
        chk("D s0_ready when full", bus.s0_ready, 0);
        chk("D s1_ready when full", bus.s1_ready, 0);
        chk("D di_en when full", bus.fft_di_en, 0);
        for (int j = 0; j < N; j++) begin
            bus.fft_do_en = 1;
            bus.fft_do_re = 16'(j);
            bus.fft_do_im = 16'(j + 100);
            step();
        end
        bus.fft_do_en = 0;
        chk("D m_last on 64th output", bus.m_last, 1);
        chk("D m_src of first frame", bus.m_src, 0);
        found = 0;
        for (int k = 0; k < 6 && found == 0; k++) begin
            step();
            if (bus.s0_ready || bus.s1_ready) found = 1;
        end
        chk("D grant after pop", found, 1);
        chk("D grant goes to s0", bus.s0_ready, 1);

        // E: FFT output with nothing in flight
        apply_reset();
        step();
        bus.fft_do_en = 1; bus.fft_do_re = 16'h0111; bus.fft_do_im = 16'h0222;
        step();
        bus.fft_do_en = 0;
        chk("E orphan set", bus.orphan, 1);
        chk("E m_valid", bus.m_valid, 1);
        chk("E m_src", bus.m_src, 0);
        chk("E m_index at 0", bus.m_index, 0);
        chk("E m_re", bus.m_re, 16'h0111);
        bus.fft_do_en = 1; bus.fft_do_re = 16'h0333;
        step();
        bus.fft_do_en = 0;
`ifdef FFT_SCHED_BITREV_IDX_EN
        idx_one = 6'd32;
`else
        idx_one = 6'd1;
`endif
        chk("E m_index at out_cnt 1", bus.m_index, idx_one);
        bus.fft_do_en = 1; bus.err_clr = 1;
        step();
        bus.fft_do_en = 0; bus.err_clr = 0;
        chk("E orphan set wins", bus.orphan, 1);
        bus.err_clr = 1;
        step();
        bus.err_clr = 0;
        chk("E orphan cleared", bus.orphan, 0);
        chk("E m_valid low", bus.m_valid, 0);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
